// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO.
// One shift-add or restoring-divide step per cycle, then a sign-fixup cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             w_clock,
    input  logic             w_reset,
    input  logic             w_valid_1,
    input  logic [5:0]       w_op_code_6,
    input  logic [WIDTH-1:0] w_input1_x,
    input  logic [WIDTH-1:0] w_input2_x,
    output logic [WIDTH-1:0] w_output_x,
    output logic             w_stall_1,
    output logic             w_busy_1,
    output logic             w_done_1,
    output logic             w_div_zero_1
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] OP_MFHI = 6'h10;
    localparam logic [5:0] OP_MTHI = 6'h11;
    localparam logic [5:0] OP_MFLO = 6'h12;
    localparam logic [5:0] OP_MTLO = 6'h13;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_q, div_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               is_md, is_listed, is_div, is_signed;
    logic               div_zero, accept, s1, s2;
    logic [WIDTH:0]     shl_rem, trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // 0x18..0x1B are the mult/div group, 0x10..0x13 the HI/LO moves
    assign is_md     = (w_op_code_6[5:2] == 4'b0110);
    assign is_listed = is_md | (w_op_code_6[5:2] == 4'b0100);
    assign is_div    = w_op_code_6[1];
    assign is_signed = ~w_op_code_6[0];
    assign div_zero  = is_div & (w_input2_x == '0);

    // A zero divisor keeps the raw dividend and positive signs, so the
    // restoring steps leave quotient all-ones and remainder = rs untouched.
    assign s1 = is_signed & ~div_zero & w_input1_x[WIDTH-1];
    assign s2 = is_signed & ~div_zero & w_input2_x[WIDTH-1];

    assign w_busy_1 = (state_q != S_IDLE);
    assign accept   = w_valid_1 & ~w_busy_1 & is_md;

    assign shl_rem  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign trial    = shl_rem - {1'b0, b_q};

    assign prod_fix = qsign_q ? -acc_q : acc_q;
    assign quo_fix  = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH]
                              : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = s1 ? -w_input1_x : w_input1_x;
                    b_d     = s2 ? -w_input2_x : w_input2_x;
                    qsign_d = s1 ^ s2;
                    rsign_d = s1;
                    div_d   = is_div;
                    dz_d    = div_zero;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    acc_d   = '0;
                    state_d = S_RUN;
                end else if (w_valid_1 && w_op_code_6 == OP_MTHI) begin
                    hi_d = w_input1_x;
                end else if (w_valid_1 && w_op_code_6 == OP_MTLO) begin
                    lo_d = w_input1_x;
                end
            end
            S_RUN: begin
                if (div_q) begin
                    // acc = {remainder, quotient bits shifted in from the right}
                    acc_d = {trial[WIDTH] ? shl_rem[WIDTH-1:0]
                                          : trial[WIDTH-1:0],
                             acc_q[WIDTH-2:0], ~trial[WIDTH]};
                    a_d   = a_q << 1;
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0}
                          + (b_q[WIDTH-1] ? {{WIDTH{1'b0}}, a_q} : '0);
                    b_d   = b_q << 1;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign w_stall_1    = w_valid_1 & w_busy_1 & is_listed;
    assign w_done_1     = done_q;
    assign w_div_zero_1 = dz_q;
    assign w_output_x   = (w_op_code_6 == OP_MFHI) ? hi_q :
                          (w_op_code_6 == OP_MFLO) ? lo_q : '0;

endmodule
